// File: rtl/vdec_hs_crc_prep_if.sv
// Frame-side and CRC-checker-side signals of the HS-SCCH CRC prep stage.
interface vdec_hs_crc_prep_if;
   logic        frm_start;
   logic        mode;
   logic [15:0] ue_id;
   logic        bit_vld;
   logic        bit_in;
   logic        busy;
   logic        crc_start;
   logic [36:0] check_bits;
   logic [5:0]  check_len;
   logic        crc_done;
   logic        crc_match_in;
   logic        res_vld;
   logic        res_pass;
   logic        res_err;
   logic [20:0] info_bits;

   // Prep stage view
   modport slave (
      input  frm_start, mode, ue_id, bit_vld, bit_in, crc_done, crc_match_in,
      output busy, crc_start, check_bits, check_len, res_vld, res_pass, res_err, info_bits
   );

   // Traceback / checker / host view
   modport master (
      output frm_start, mode, ue_id, bit_vld, bit_in, crc_done, crc_match_in,
      input  busy, crc_start, check_bits, check_len, res_vld, res_pass, res_err, info_bits
   );
endinterface

// File: rtl/vdec_hs_crc_prep.sv
// HS-SCCH CRC prep: collects decoded bits, de-masks the CRC field with the
// UE identity, launches the serial CRC checker and reports pass/fail.
module vdec_hs_crc_prep #(
   parameter int unsigned TIMEOUT = 63
) (
   input  logic                 clk,
   input  logic                 rst,
   vdec_hs_crc_prep_if.slave    bus
);

   localparam int unsigned WORD_W = 37;
   localparam int unsigned LEN_W  = 6;
   localparam int unsigned UE_W   = 16;
   localparam int unsigned INFO_W = 21;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      MASK,
      LAUNCH,
      WAIT,
      REPORT
   } state_t;

   state_t              state_q;
   logic [WORD_W-1:0]   bits_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    cnt_q;
   logic [LEN_W-1:0]    wait_q;
   logic                mode_q;
   logic [UE_W-1:0]     ue_q;
   logic                ovf_q;
   logic                busy_q;
   logic                start_q;
   logic                vld_q;
   logic                pass_q;
   logic                err_q;
   logic [WORD_W-1:0]   mask_d;

   // UE identity aligned to the CRC field, which sits just above the info bits
   always_comb begin
      mask_d = '0;
      if (mode_q) begin
         mask_d = WORD_W'({ue_q, 6'd0});
      end else begin
         mask_d = {ue_q, 21'd0};
      end
   end

   // Frame FSM; frm_start overrides everything and restarts collection
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bits_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         wait_q  <= '0;
         mode_q  <= 1'b0;
         ue_q    <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         vld_q   <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         vld_q   <= 1'b0;
         if (bus.frm_start) begin
            state_q <= COLLECT;
            bits_q  <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            ovf_q   <= 1'b0;
            mode_q  <= bus.mode;
            ue_q    <= bus.ue_id;
            len_q   <= bus.mode ? LEN_W'(22) : LEN_W'(37);
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= IDLE;
               end
               COLLECT: begin
                  if (bus.bit_vld) begin
                     bits_q[cnt_q] <= bus.bit_in;
                     cnt_q         <= cnt_q + LEN_W'(1);
                     if (cnt_q == len_q - LEN_W'(1)) begin
                        state_q <= MASK;
                     end
                  end
               end
               MASK: begin
                  bits_q  <= bits_q ^ mask_d;
                  start_q <= 1'b1;
                  state_q <= LAUNCH;
                  if (bus.bit_vld) begin
                     ovf_q <= 1'b1;
                  end
               end
               LAUNCH: begin
                  wait_q  <= '0;
                  state_q <= WAIT;
                  if (bus.bit_vld) begin
                     ovf_q <= 1'b1;
                  end
               end
               WAIT: begin
                  if (bus.bit_vld) begin
                     ovf_q <= 1'b1;
                  end
                  if (bus.crc_done) begin
                     pass_q  <= bus.crc_match_in & ~ovf_q;
                     err_q   <= ovf_q;
                     vld_q   <= 1'b1;
                     state_q <= REPORT;
                  end else if (wait_q == LEN_W'(TIMEOUT)) begin
                     pass_q  <= 1'b0;
                     err_q   <= 1'b1;
                     vld_q   <= 1'b1;
                     state_q <= REPORT;
                  end else begin
                     wait_q <= wait_q + LEN_W'(1);
                  end
               end
               REPORT: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy       = busy_q;
   assign bus.crc_start  = start_q;
   assign bus.check_bits = bits_q;
   assign bus.check_len  = len_q;
   assign bus.res_vld    = vld_q;
   assign bus.res_pass   = pass_q;
   assign bus.res_err    = err_q;
   assign bus.info_bits  = bits_q[INFO_W-1:0];

endmodule
